// File: rtl/aes_dec_arbiter.sv
// aes_dec_arbiter: round-robin front end that shares one AES-128 inverse-cipher core among NREQ requesters.
// Optional core watchdog is compiled in when AES_ARB_TIMEOUT_EN is defined.
module aes_dec_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*128-1:0]  req_ct,
    input  logic [NREQ*128-1:0]  req_key,
    output logic                 core_start,
    output logic [127:0]         core_ct,
    output logic [127:0]         core_key,
    input  logic                 core_ready,
    input  logic [127:0]         core_pt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [127:0]         rsp_pt,
    output logic                 rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] w_gnt;
    logic [IDW-1:0] w_ptr_nxt;
    logic           w_any;
    logic           w_wd_expire;
    logic [127:0]   r_core_ct;
    logic [127:0]   r_core_key;
    logic [127:0]   r_rsp_pt;
    logic [IDW-1:0] r_rsp_id;
    logic           r_rsp_err;

    // Rotating-priority search: scanning from the far end lets the nearest valid index win last.
    always_comb begin
        int v_idx;
        w_any = 1'b0;
        w_gnt = '0;
        v_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_idx = (int'(r_ptr) + k) % NREQ;
            w_gnt = req_valid[v_idx] ? IDW'(v_idx) : w_gnt;
            w_any = w_any | req_valid[v_idx];
        end
        w_ptr_nxt = IDW'((int'(w_gnt) + 1) % NREQ);
    end

    // One-hot accept, offered only while idle.
    always_comb begin
        req_ready = '0;
        if ((r_state == ST_IDLE) && w_any) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt;
        end else begin
            req_ready = '0;
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] r_wd_cnt;

    // Watchdog counts WAIT cycles; cleared while the start pulse is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wd_cnt <= r_wd_cnt + CW'(1);
        end else begin
            r_wd_cnt <= r_wd_cnt;
        end
    end

    assign w_wd_expire = (r_state == ST_WAIT) && !core_ready && (r_wd_cnt == CW'(TIMEOUT - 1));
`else
    assign w_wd_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_any ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = (core_ready || w_wd_expire) ? ST_RESP : ST_WAIT;
            ST_RESP:  w_state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Job capture on accept and response capture on core completion or watchdog abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_core_ct  <= '0;
            r_core_key <= '0;
            r_rsp_pt   <= '0;
            r_rsp_id   <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_core_ct  <= req_ct[128*int'(w_gnt) +: 128];
                        r_core_key <= req_key[128*int'(w_gnt) +: 128];
                        r_owner    <= w_gnt;
                        r_ptr      <= w_ptr_nxt;
                    end
                end
                ST_WAIT: begin
                    if (core_ready) begin
                        r_rsp_pt  <= core_pt;
                        r_rsp_id  <= r_owner;
                        r_rsp_err <= 1'b0;
                    end else if (w_wd_expire) begin
                        r_rsp_pt  <= '0;
                        r_rsp_id  <= r_owner;
                        r_rsp_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign core_start = (r_state == ST_ISSUE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign core_ct    = r_core_ct;
    assign core_key   = r_core_key;
    assign rsp_pt     = r_rsp_pt;
    assign rsp_id     = r_rsp_id;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Directed self-checking bench for aes_dec_arbiter with a behavioural two-edge core model.
// Watchdog steps are compiled only when AES_ARB_TIMEOUT_EN is defined.
module tb_aes_dec_arbiter;

    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = 4'd0;
    logic [3:0]   req_ready;
    logic [511:0] req_ct = 512'd0;
    logic [511:0] req_key = 512'd0;
    logic         core_start;
    logic [127:0] core_ct, core_key;
    logic         core_ready;
    logic [127:0] core_pt;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [2:0]   rsp_id;
    logic [127:0] rsp_pt;
    logic         rsp_err;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    logic stuck = 1'b0;
    logic [1:0] m_cnt;

    aes_dec_arbiter #(.NREQ(4), .IDW(3), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ct(req_ct), .req_key(req_key),
        .core_start(core_start), .core_ct(core_ct), .core_key(core_key),
        .core_ready(core_ready), .core_pt(core_pt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_pt(rsp_pt), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ct_of(input int i);
        return {8{16'hA000 + 16'(i)}};
    endfunction

    function automatic logic [127:0] key_of(input int i);
        return {8{16'hB000 + 16'(i)}};
    endfunction

    function automatic logic [127:0] core_fn(input logic [127:0] ct, input logic [127:0] key);
        if (ct == CT0 && key == K0) return PT0;
        return ct ^ key;
    endfunction

    // Core model: ready is dropped on the start edge and raised two edges later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_ready <= 1'b0;
            m_cnt      <= 2'd0;
            core_pt    <= 128'd0;
        end else if (core_start) begin
            core_ready <= 1'b0;
            m_cnt      <= 2'd2;
            core_pt    <= core_fn(core_ct, core_key);
        end else if (m_cnt == 2'd2) begin
            m_cnt <= 2'd1;
        end else if (m_cnt == 2'd1) begin
            m_cnt <= 2'd0;
            if (!stuck) core_ready <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (core_start === 1'b1) n_start <= n_start + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output int lat);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            if (core_start === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int s0;
        int seen;
        logic [127:0] exp_pt;

        // Reset state
        #1 rst = 1'b0;
        #10;
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_core_start", 128'(core_start), 128'd0);
        chk("rst_core_ct", core_ct, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_id", 128'(rsp_id), 128'd0);
        chk("rst_rsp_pt", rsp_pt, 128'd0);
        chk("rst_rsp_err", 128'(rsp_err), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Round robin with all four requesters held high
        for (int i = 0; i < 4; i++) begin
            req_ct[128*i +: 128]  = ct_of(i);
            req_key[128*i +: 128] = key_of(i);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1 chk("rr_first_ready", 128'(req_ready), 128'h1);
        for (int j = 0; j < 5; j++) begin
            s0 = n_start;
            wait_start(lat);
            chk("rr_start_seen", 128'(lat >= 0), 128'd1);
            chk("rr_core_ct", core_ct, ct_of(j % 4));
            chk("rr_core_key", core_key, key_of(j % 4));
            wait_rsp(lat);
            chk("rr_rsp_lat", 128'(lat), 128'd4);
            chk("rr_rsp_id", 128'(rsp_id), 128'(j % 4));
            chk("rr_rsp_pt", rsp_pt, ct_of(j % 4) ^ key_of(j % 4));
            chk("rr_ct_hold", core_ct, ct_of(j % 4));
            chk("rr_one_start", 128'(n_start - s0), 128'd1);
            if (j == 4) req_valid = 4'b0000;
        end
        @(negedge clk);
        @(negedge clk);

        // Single job from requester 2 with the reference vector
        req_ct[256 +: 128]  = CT0;
        req_key[256 +: 128] = K0;
        req_valid = 4'b0100;
        #1 chk("sj_req_ready", 128'(req_ready), 128'h4);
        wait_start(lat);
        chk("sj_start_lat", 128'(lat), 128'd1);
        req_valid = 4'b0000;
        wait_rsp(lat);
        chk("sj_rsp_lat", 128'(lat), 128'd4);
        chk("sj_rsp_id", 128'(rsp_id), 128'd2);
        chk("sj_rsp_pt", rsp_pt, PT0);
        chk("sj_rsp_err", 128'(rsp_err), 128'd0);
        @(negedge clk);
        @(negedge clk);

        // Backpressure: response held 10 cycles, then released
        rsp_ready = 1'b0;
        req_valid = 4'b1001;
        #1 chk("bp_req_ready", 128'(req_ready), 128'h8);
        wait_start(lat);
        wait_rsp(lat);
        chk("bp_rsp_lat", 128'(lat), 128'd4);
        exp_pt = ct_of(3) ^ key_of(3);
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold_ctrl", {rsp_valid, rsp_id, req_ready, core_start, rsp_err}, {1'b1, 3'd3, 4'd0, 1'b0, 1'b0});
            chk("bp_hold_pt", rsp_pt, exp_pt);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(rsp_valid), 128'd0);
        chk("bp_release_ready", 128'(req_ready), 128'h1);
        req_valid = 4'b0000;
        @(negedge clk);

        // Reset pulsed during WAIT drops the job and rewinds the pointer
        req_valid = 4'b0100;
        wait_start(lat);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_outputs", {req_ready, core_start, rsp_valid, rsp_id, rsp_err}, 128'd0);
        chk("mr_core_ct", core_ct, 128'd0);
        chk("mr_core_key", core_key, 128'd0);
        chk("mr_rsp_pt", rsp_pt, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || core_start === 1'b1) seen++;
        end
        chk("mr_no_rsp", 128'(seen), 128'd0);
        req_valid = 4'b1111;
        #1 chk("mr_grant_from0", 128'(req_ready), 128'h1);
        wait_start(lat);
        req_valid = 4'b0000;
        wait_rsp(lat);
        chk("mr_next_lat", 128'(lat), 128'd4);
        chk("mr_next_id", 128'(rsp_id), 128'd0);
        chk("mr_next_pt", rsp_pt, ct_of(0) ^ key_of(0));
        @(negedge clk);
        @(negedge clk);

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog abort with a stuck core, then a normal job
        stuck = 1'b1;
        req_valid = 4'b0010;
        #1 chk("wd_req_ready", 128'(req_ready), 128'h2);
        wait_start(lat);
        req_valid = 4'b0000;
        wait_rsp(lat);
        chk("wd_rsp_lat", 128'(lat), 128'd9);
        chk("wd_rsp_err", 128'(rsp_err), 128'd1);
        chk("wd_rsp_pt", rsp_pt, 128'd0);
        chk("wd_rsp_id", 128'(rsp_id), 128'd1);
        stuck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req_valid = 4'b0100;
        wait_start(lat);
        req_valid = 4'b0000;
        wait_rsp(lat);
        chk("wd_after_lat", 128'(lat), 128'd4);
        chk("wd_after_err", 128'(rsp_err), 128'd0);
        chk("wd_after_id", 128'(rsp_id), 128'd2);
        chk("wd_after_pt", rsp_pt, PT0);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
